// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4-Lite arbiter:
// transaction FSM encoding and AXI response codes.
package axi_lite_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR_DATA,
        ST_WR_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt = ~last_grant;
        end else begin
            gnt = req1;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one downstream AXI4-Lite port between two requesters, one
// transaction in flight at a time, grant held until the response handshake.
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [2:0]              s0_arprot,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [2:0]              s0_awprot,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,

    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [2:0]              s1_arprot,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [2:0]              s1_awprot,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,

    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_grant_q, last_grant_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   req0, req1, arb_valid, arb_gnt, arb_is_wr;
    logic   in_rd_addr, in_rd_data, in_wr_ad, in_wr_resp;
    logic   sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;

    // A requester's write needs both AW and W present before it counts.
    assign req0      = s0_arvalid | (s0_awvalid & s0_wvalid);
    assign req1      = s1_arvalid | (s1_awvalid & s1_wvalid);
    assign arb_is_wr = arb_gnt ? (s1_awvalid & s1_wvalid) : (s0_awvalid & s0_wvalid);

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt_valid  (arb_valid),
        .gnt        (arb_gnt)
    );

    assign in_rd_addr = (state_q == ST_RD_ADDR);
    assign in_rd_data = (state_q == ST_RD_DATA);
    assign in_wr_ad   = (state_q == ST_WR_ADDR_DATA);
    assign in_wr_resp = (state_q == ST_WR_RESP);

    assign sel_arvalid = gnt_q ? s1_arvalid : s0_arvalid;
    assign sel_awvalid = gnt_q ? s1_awvalid : s0_awvalid;
    assign sel_wvalid  = gnt_q ? s1_wvalid  : s0_wvalid;
    assign sel_rready  = gnt_q ? s1_rready  : s0_rready;
    assign sel_bready  = gnt_q ? s1_bready  : s0_bready;

    assign m_araddr  = gnt_q ? s1_araddr : s0_araddr;
    assign m_arprot  = gnt_q ? s1_arprot : s0_arprot;
    assign m_awaddr  = gnt_q ? s1_awaddr : s0_awaddr;
    assign m_awprot  = gnt_q ? s1_awprot : s0_awprot;
    assign m_wdata   = gnt_q ? s1_wdata  : s0_wdata;
    assign m_wstrb   = gnt_q ? s1_wstrb  : s0_wstrb;

    assign m_arvalid = in_rd_addr & sel_arvalid;
    assign m_rready  = in_rd_data & sel_rready;
    assign m_awvalid = in_wr_ad & ~aw_done_q & sel_awvalid;
    assign m_wvalid  = in_wr_ad & ~w_done_q & sel_wvalid;
    assign m_bready  = in_wr_resp & sel_bready;

    // Response payloads fan out to both sides; only the valids are steered.
    assign s0_rdata   = m_rdata;
    assign s0_rresp   = m_rresp;
    assign s1_rdata   = m_rdata;
    assign s1_rresp   = m_rresp;
    assign s0_bresp   = m_bresp;
    assign s1_bresp   = m_bresp;

    assign s0_arready = in_rd_addr & ~gnt_q & m_arready;
    assign s1_arready = in_rd_addr &  gnt_q & m_arready;
    assign s0_rvalid  = in_rd_data & ~gnt_q & m_rvalid;
    assign s1_rvalid  = in_rd_data &  gnt_q & m_rvalid;
    assign s0_awready = in_wr_ad & ~aw_done_q & ~gnt_q & m_awready;
    assign s1_awready = in_wr_ad & ~aw_done_q &  gnt_q & m_awready;
    assign s0_wready  = in_wr_ad & ~w_done_q & ~gnt_q & m_wready;
    assign s1_wready  = in_wr_ad & ~w_done_q &  gnt_q & m_wready;
    assign s0_bvalid  = in_wr_resp & ~gnt_q & m_bvalid;
    assign s1_bvalid  = in_wr_resp &  gnt_q & m_bvalid;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d        = arb_gnt;
                    last_grant_d = arb_gnt;
                    state_d      = arb_is_wr ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (m_arvalid && m_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (m_rvalid && m_rready) state_d = ST_IDLE;
            end
            ST_WR_ADDR_DATA: begin
                // AW and W complete in any order, possibly in the same cycle.
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q  | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid && m_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Randomized bench: two requester drivers, a randomly stalling MMU slave,
// and a transaction-level reference of grant order and channel routing.
module tb_axi_lite_arbiter;
    import axi_lite_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0][31:0] araddr, awaddr, wdata, rdata;
    logic [1:0][2:0]  arprot, awprot;
    logic [1:0][3:0]  wstrb;
    logic [1:0][1:0]  rresp, bresp;
    logic [1:0]       arvalid, arready, rvalid, rready, awvalid, awready;
    logic [1:0]       wvalid, wready, bvalid, bready;

    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [2:0]  m_arprot, m_awprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready;

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .s0_araddr(araddr[0]), .s0_arprot(arprot[0]), .s0_arvalid(arvalid[0]), .s0_arready(arready[0]),
        .s0_rdata(rdata[0]), .s0_rresp(rresp[0]), .s0_rvalid(rvalid[0]), .s0_rready(rready[0]),
        .s0_awaddr(awaddr[0]), .s0_awprot(awprot[0]), .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
        .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
        .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
        .s1_araddr(araddr[1]), .s1_arprot(arprot[1]), .s1_arvalid(arvalid[1]), .s1_arready(arready[1]),
        .s1_rdata(rdata[1]), .s1_rresp(rresp[1]), .s1_rvalid(rvalid[1]), .s1_rready(rready[1]),
        .s1_awaddr(awaddr[1]), .s1_awprot(awprot[1]), .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
        .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
        .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Slave behaviour: read data and response codes are a fixed function of address.
    function automatic logic [31:0] rd_data_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [1:0] resp_fn(input logic [31:0] a);
        case (a[3:2])
            2'd2:    return RESP_SLVERR;
            2'd3:    return RESP_DECERR;
            default: return RESP_OKAY;
        endcase
    endfunction

    // ---------------- MMU slave model ----------------
    bit hold_r = 1'b0;
    bit rd_pend, aw_got, w_got, b_pend;
    int r_cnt, b_cnt;
    logic [31:0] s_raddr, s_waddr;

    initial begin
        {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;
        {rd_pend, aw_got, w_got, b_pend} = '0;
        r_cnt = 0; b_cnt = 0; s_raddr = '0; s_waddr = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                {rd_pend, aw_got, w_got, b_pend} = '0;
            end else begin
                if (m_rvalid && m_rready) rd_pend = 0;
                if (m_bvalid && m_bready) b_pend = 0;
                if (m_arvalid && m_arready) begin
                    rd_pend = 1; s_raddr = m_araddr; r_cnt = $urandom_range(0, 3);
                end
                if (m_awvalid && m_awready) begin aw_got = 1; s_waddr = m_awaddr; end
                if (m_wvalid && m_wready) w_got = 1;
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = $urandom_range(0, 3);
                end
            end
            @(posedge clk); #1;
            m_arready = ($urandom_range(0, 2) != 0);
            m_awready = ($urandom_range(0, 2) != 0);
            m_wready  = ($urandom_range(0, 2) != 0);
            if (!rd_pend) begin
                m_rvalid = 0; m_rdata = $urandom; m_rresp = 2'($urandom);
            end else if (!m_rvalid) begin
                if (r_cnt == 0 && !hold_r) begin
                    m_rvalid = 1; m_rdata = rd_data_fn(s_raddr); m_rresp = resp_fn(s_raddr);
                end else if (r_cnt > 0) r_cnt--;
            end
            if (!b_pend) begin
                m_bvalid = 0; m_bresp = 2'($urandom);
            end else if (!m_bvalid) begin
                if (b_cnt == 0) begin m_bvalid = 1; m_bresp = resp_fn(s_waddr); end
                else b_cnt--;
            end
        end
    end

    // ---------------- transaction-level reference ----------------
    bit busy = 0, mwr = 0, awd = 0, wdn = 0, last_g = 1, own = 0, ph = 0;
    bit log_own[$];
    bit log_wr[$];

    always @(negedge clk) begin : ref_model
        logic [14:0] obs, exp;
        logic        e_arv, e_awv, e_wv, e_rr, e_br, done, ph_nx;
        logic [1:0]  e_arr, e_awr, e_wr, e_rv, e_bv, pw, pend;
        obs = {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
               arready, awready, wready, rvalid, bvalid};
        {e_arv, e_awv, e_wv, e_rr, e_br, done} = '0;
        {e_arr, e_awr, e_wr, e_rv, e_bv} = '0;
        ph_nx = ph;
        if (!rstn) begin
            busy = 0; last_g = 1;
        end else if (!busy) begin
            chk("idle_ctl", obs, 15'd0);
            pw   = awvalid & wvalid;
            pend = arvalid | pw;
            if (pend != 2'b00) begin
                own  = (pend == 2'b11) ? ~last_g : pend[1];
                last_g = own;
                mwr  = pw[own];
                busy = 1; ph = 0; awd = 0; wdn = 0;
                log_own.push_back(own);
                log_wr.push_back(mwr);
            end
        end else begin
            if (!mwr && ph == 0) begin
                e_arv = arvalid[own];
                e_arr[own] = m_arready;
                if (e_arv) chk("ar_pay", {m_araddr, m_arprot}, {araddr[own], arprot[own]});
                if (e_arv && m_arready) ph_nx = 1;
            end else if (!mwr) begin
                e_rv[own] = m_rvalid;
                e_rr = rready[own];
                if (m_rvalid) chk("r_route", {rdata[own], rresp[own]}, {m_rdata, m_rresp});
                done = m_rvalid & rready[own];
            end else if (ph == 0) begin
                e_awv = ~awd & awvalid[own];
                e_wv  = ~wdn & wvalid[own];
                e_awr[own] = ~awd & m_awready;
                e_wr[own]  = ~wdn & m_wready;
                if (e_awv) chk("aw_pay", {m_awaddr, m_awprot}, {awaddr[own], awprot[own]});
                if (e_wv)  chk("w_pay", {m_wdata, m_wstrb}, {wdata[own], wstrb[own]});
                awd = awd | (e_awv & m_awready);
                wdn = wdn | (e_wv & m_wready);
                if (awd && wdn) ph_nx = 1;
            end else begin
                e_bv[own] = m_bvalid;
                e_br = bready[own];
                if (m_bvalid) chk("b_route", bresp[own], m_bresp);
                done = m_bvalid & bready[own];
            end
            exp = {e_arv, e_awv, e_wv, e_rr, e_br, e_arr, e_awr, e_wr, e_rv, e_bv};
            chk(mwr ? "wr_ctl" : "rd_ctl", obs, exp);
            ph = ph_nx;
            if (done) busy = 0;
        end
    end

    // ---------------- requester driver ----------------
    task automatic do_txn(input int n, input bit rd, input bit wr);
        logic [31:0] ra, wa;
        bit ar_d, r_d, aw_d, w_d, b_d;
        int cyc;
        ra = $urandom & 32'hFFFF_FFFC;
        wa = $urandom & 32'hFFFF_FFFC;
        ar_d = !rd; r_d = !rd; aw_d = !wr; w_d = !wr; b_d = !wr; cyc = 0;
        araddr[n] = ra; arprot[n] = 3'($urandom);
        awaddr[n] = wa; awprot[n] = 3'($urandom);
        wdata[n] = $urandom; wstrb[n] = 4'($urandom);
        arvalid[n] = !ar_d; awvalid[n] = !aw_d; wvalid[n] = !w_d;
        while (!(r_d && b_d) && cyc < 400) begin
            rready[n] = !r_d && ($urandom_range(0, 3) != 0);
            bready[n] = !b_d && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            if (arvalid[n] && arready[n]) ar_d = 1;
            if (awvalid[n] && awready[n]) aw_d = 1;
            if (wvalid[n] && wready[n]) w_d = 1;
            if (rvalid[n] && rready[n]) begin
                chk("rdata", {rdata[n], rresp[n]}, {rd_data_fn(ra), resp_fn(ra)});
                r_d = 1;
            end
            if (bvalid[n] && bready[n]) begin
                chk("bresp", bresp[n], resp_fn(wa));
                b_d = 1;
            end
            @(posedge clk); #1;
            arvalid[n] = !ar_d; awvalid[n] = !aw_d; wvalid[n] = !w_d;
        end
        arvalid[n] = 0; awvalid[n] = 0; wvalid[n] = 0; rready[n] = 0; bready[n] = 0;
        if (cyc >= 400) chk("txn_timeout", cyc, 0);
    endtask

    task automatic req_loop(input int n, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int k, g;
            k = $urandom_range(0, 9);
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            do_txn(n, (k < 4) || (k >= 8), k >= 4);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin : main
        int b, cyc;
        logic [3:0] ord;
        rstn = 0;
        araddr = '0; awaddr = '0; wdata = '0; arprot = '0; awprot = '0; wstrb = '0;
        arvalid = '0; awvalid = '0; wvalid = '0; rready = '0; bready = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        chk("rst_outs", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                         arready, awready, wready, rvalid, bvalid}, 15'd0);
        @(posedge clk); #1;

        // Simultaneous reads from both sides alternate, requester 0 first.
        b = log_own.size();
        repeat (2) fork do_txn(0, 1, 0); do_txn(1, 1, 0); join
        for (int i = 0; i < 4; i++) ord[3-i] = log_own[b+i];
        chk("rr_order", ord, 4'b0101);

        // Read and write pending together at one requester: write first.
        b = log_own.size();
        do_txn(0, 1, 1);
        chk("wr_first", {log_own[b], log_wr[b], log_own[b+1], log_wr[b+1]}, 4'b0100);

        fork req_loop(0, 40); req_loop(1, 40); join

        // Reset while the slave stalls a read in its data phase.
        hold_r = 1;
        araddr[0] = 32'h0000_1000; arprot[0] = 3'd0; arvalid[0] = 1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!arready[0] && cyc < 100);
        chk("rst_ar_hs", arready[0], 1'b1);
        @(posedge clk); #1 arvalid[0] = 0;
        repeat (2) begin @(posedge clk); #1; end
        rstn = 0;
        @(posedge clk); #1 rstn = 1; hold_r = 0;
        @(negedge clk);
        chk("rst_mid", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                        arready, awready, wready, rvalid, bvalid}, 15'd0);
        @(posedge clk); #1;

        // After reset the first tie goes to requester 0 again.
        b = log_own.size();
        fork do_txn(0, 1, 0); do_txn(1, 1, 0); join
        chk("rst_rr", {log_own[b], log_own[b+1]}, 2'b01);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
